// File: rtl/opcode_tag_decoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | opcode_tag_decoder_pkg                                             |
// | Shared opcode tag types, decoded-op struct and tag legality limit. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package opcode_tag_decoder_pkg;

    localparam int DWORD_LOG2          = 6;
    localparam int OPCODE_INDEX_W      = DWORD_LOG2;
    localparam int OPCODE_TAG_W        = 9;
    localparam logic [31:0] OPCODE_TAG_MAX_LEGAL = 32'h13F;

    typedef logic [OPCODE_TAG_W-1:0] opcodeTagT;

    typedef enum logic [2:0] {
        OPCODEATYPE_READ  = 3'd0,
        OPCODEATYPE_WRITE = 3'd1,
        OPCODEATYPE_WAIT  = 3'd2,
        OPCODEATYPE_EVICT = 3'd3,
        OPCODEATYPE_TRIM  = 3'd4
    } opcodeEnumT;

    typedef struct packed {
        opcodeEnumT                opType;
        logic [OPCODE_INDEX_W-1:0] index;
    } decodedOpSt;

endpackage
`default_nettype wire

// File: rtl/opcode_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | opcode_fifo                                                        |
// | Synchronous FIFO with flop storage, head read straight from flops. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module opcode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i)
            count_d = count_q + CNT_W'(1);
        else if (pop_i && !push_i)
            count_d = count_q - CNT_W'(1);
    end

    // When full, a simultaneous push overwrites the slot being popped; the
    // popped value is the pre-edge contents, so ordering is preserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o && !pop_i));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop_i && empty_o));

endmodule
`default_nettype wire

// File: rtl/opcode_tag_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | opcode_tag_decoder                                                 |
// | Splits opcode tags into {type,index}, buffers them, counts illegal.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module opcode_tag_decoder
    import opcode_tag_decoder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tag_valid,
    output logic                    tag_ready,
    input  logic [8:0]              tag,
    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [8:0]              op,
    output logic                    err_sticky,
    output logic [ERR_CNT_W-1:0]    err_count,
    input  logic                    err_clr,
    output logic [$clog2(DEPTH):0]  occupancy
);

    decodedOpSt             dec_w;
    logic                   legal_w;
    logic                   accept_w;
    logic                   push_w;
    logic                   pop_w;
    logic                   full_w;
    logic                   empty_w;
    logic                   ready_q;
    logic                   err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

    assign dec_w.opType = opcodeEnumT'(tag[8:6]);
    assign dec_w.index  = tag[OPCODE_INDEX_W-1:0];
    assign legal_w      = ({23'd0, tag} <= OPCODE_TAG_MAX_LEGAL);

    // Held low through reset; rises on the first clock after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= 1'b1;
    end

    assign pop_w     = op_valid && op_ready;
    assign tag_ready = ready_q && (!legal_w || !full_w || pop_w);
    assign accept_w  = tag_valid && tag_ready;
    assign push_w    = accept_w && legal_w;

    opcode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(decodedOpSt))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_w),
        .din_i   (dec_w),
        .pop_i   (pop_w),
        .dout_o  (op),
        .full_o  (full_w),
        .empty_o (empty_w),
        .count_o (occupancy)
    );

    assign op_valid = !empty_w;

    always_comb begin
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end else if (accept_w && !legal_w) begin
            err_sticky_d = 1'b1;
            if (err_count_q != '1)
                err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

    a_op_type_legal: assert property (@(posedge clk) disable iff (rst)
        op_valid |-> (op[8:6] <= OPCODEATYPE_TRIM));
    a_op_stable: assert property (@(posedge clk) disable iff (rst)
        (op_valid && !op_ready) |=> (op_valid && $stable(op)));

endmodule
`default_nettype wire
